// File: rtl/gs_vector_buffer.sv
// ---------------------------------------------------------------------------
// gs_vector_buffer
//
// Circulating storage for the Gauss-Seidel solver datapath. The right-hand
// side vector b and the solution vector x live in two rotating rings. Index 0
// of each ring always holds the current row, so the row update unit sees a
// fixed window of registers and never has to do random access.
//
// Optional feature macro: GSBUF_CONVERGE_EN
//   When defined, adds parameter TOL and output converged_out. The block then
//   also stops early when a whole sweep changes no x entry by more than TOL.
//
// Ports
//   clk_in          clock, all state on rising edge
//   rst_in          synchronous active-high reset
//   load_valid_in   b_in word valid
//   load_ready_out  buffer accepting b words (IDLE, LOAD, DONE)
//   b_in            b element, row 0 first
//   sweep_limit_in  sweep count, sampled on first accepted b word (0 -> 1)
//   x_valid_in      updated x for current row valid (RUN only)
//   x_in            updated x for current row
//   b_out           b of current row (b ring head)
//   x_taps_out      packed neighbours: slot 2(k-1) = upper k,
//                   slot 2(k-1)+1 = lower k, slot 0 in the LSBs
//   row_out         current row index
//   start_out       high in RUN
//   sweep_done_out  one-cycle pulse after the row wraps N-1 -> 0
//   iter_out        completed sweeps
//   done_out        high in DONE
//   converged_out   (GSBUF_CONVERGE_EN only) early-stop indicator
//
// Handshakes: a transfer happens on a rising edge where the valid input is
// high and the buffer is in a state that accepts it (load_ready_out for b,
// RUN for x). Valid may drop at any time; nothing is consumed while it is low.
// ---------------------------------------------------------------------------
module gs_vector_buffer #(
  parameter int N    = 16,
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int TAPS = 3,
  parameter int IW   = 8
`ifdef GSBUF_CONVERGE_EN
  ,
  parameter int TOL  = 16
`endif
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   load_valid_in,
  output logic                   load_ready_out,
  input  logic [BW-1:0]          b_in,
  input  logic [IW-1:0]          sweep_limit_in,
  input  logic                   x_valid_in,
  input  logic [XW-1:0]          x_in,
  output logic [BW-1:0]          b_out,
  output logic [2*TAPS*XW-1:0]   x_taps_out,
  output logic [$clog2(N)-1:0]   row_out,
  output logic                   start_out,
  output logic                   sweep_done_out,
  output logic [IW-1:0]          iter_out,
  output logic                   done_out
`ifdef GSBUF_CONVERGE_EN
  ,
  output logic                   converged_out
`endif
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   b_q [N];
  logic [BW-1:0]   b_d [N];
  logic [XW-1:0]   x_q [N];
  logic [XW-1:0]   x_d [N];
  logic [RW-1:0]   row_q, row_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [IW-1:0]   limit_q, limit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sweep_done_q, sweep_done_d;
  logic [IW-1:0]   iter_inc;
  logic            load_hs;
  logic            step;
  logic            exceed;

`ifdef GSBUF_CONVERGE_EN
  localparam logic [XW:0] TOL_W = (XW + 1)'(TOL);
  logic            dirty_q, dirty_d;
  logic            converged_q, converged_d;
  logic signed [XW:0] diff;
  logic [XW:0]     mag;

  // Sign-extend both operands by one bit so the difference cannot overflow.
  always_comb begin
    diff   = $signed({x_in[XW-1], x_in}) - $signed({x_q[0][XW-1], x_q[0]});
    mag    = diff[XW] ? -diff : diff;
    exceed = (mag > TOL_W);
  end
`else
  assign exceed = 1'b0;
`endif

  assign load_hs  = load_valid_in && (state_q != S_RUN);
  assign step     = x_valid_in && (state_q == S_RUN);
  assign iter_inc = iter_q + IW'(1);

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    x_d          = x_q;
    row_d        = row_q;
    iter_d       = iter_q;
    limit_d      = limit_q;
    cnt_d        = cnt_q;
    sweep_done_d = 1'b0;
`ifdef GSBUF_CONVERGE_EN
    dirty_d      = dirty_q;
    converged_d  = converged_q;
`endif

    // Every accepted b word enters at the tail; after N words the first
    // word has walked down to the head (index 0).
    if (load_hs) begin
      for (int i = 0; i < N - 1; i++) b_d[i] = b_q[i+1];
      b_d[N-1] = b_in;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_hs) begin
          cnt_d   = CW'(1);
          limit_d = (sweep_limit_in == '0) ? IW'(1) : sweep_limit_in;
          state_d = S_LOAD;
`ifdef GSBUF_CONVERGE_EN
          converged_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_RUN;
            row_d   = '0;
            iter_d  = '0;
            cnt_d   = '0;
`ifdef GSBUF_CONVERGE_EN
            dirty_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RUN: begin
        if (step) begin
          // b rotates head to tail; x shifts with the fresh value at the
          // tail, so x_q[N-k] is always the already-updated row-k neighbour.
          for (int i = 0; i < N - 1; i++) begin
            b_d[i] = b_q[i+1];
            x_d[i] = x_q[i+1];
          end
          b_d[N-1] = b_q[0];
          x_d[N-1] = x_in;
          if (row_q == ROW_LAST) begin
            row_d        = '0;
            sweep_done_d = 1'b1;
            iter_d       = iter_inc;
            if (iter_inc == limit_q) state_d = S_DONE;
`ifdef GSBUF_CONVERGE_EN
            if (!(dirty_q || exceed)) begin
              state_d     = S_DONE;
              converged_d = 1'b1;
            end
            dirty_d = 1'b0;
`endif
          end else begin
            row_d = row_q + RW'(1);
`ifdef GSBUF_CONVERGE_EN
            dirty_d = dirty_q || exceed;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
      row_q        <= '0;
      iter_q       <= '0;
      limit_q      <= '0;
      cnt_q        <= '0;
      sweep_done_q <= 1'b0;
`ifdef GSBUF_CONVERGE_EN
      dirty_q      <= 1'b0;
      converged_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      x_q          <= x_d;
      row_q        <= row_d;
      iter_q       <= iter_d;
      limit_q      <= limit_d;
      cnt_q        <= cnt_d;
      sweep_done_q <= sweep_done_d;
`ifdef GSBUF_CONVERGE_EN
      dirty_q      <= dirty_d;
      converged_q  <= converged_d;
`endif
    end
  end

  // Banded neighbours; out-of-matrix neighbours read as zero.
  always_comb begin
    x_taps_out = '0;
    for (int k = 1; k <= TAPS; k++) begin
      if (int'(row_q) + k <= N - 1) x_taps_out[(2*(k-1))*XW +: XW] = x_q[k];
      if (int'(row_q) >= k)         x_taps_out[(2*(k-1)+1)*XW +: XW] = x_q[N-k];
    end
  end

  assign b_out          = b_q[0];
  assign row_out        = row_q;
  assign iter_out       = iter_q;
  assign sweep_done_out = sweep_done_q;
  assign start_out      = (state_q == S_RUN);
  assign done_out       = (state_q == S_DONE);
  assign load_ready_out = (state_q != S_RUN);
`ifdef GSBUF_CONVERGE_EN
  assign converged_out  = converged_q;
`endif

endmodule

// File: tb/tb_gs_vector_buffer.sv
module tb_gs_vector_buffer;

  localparam int N    = 16;
  localparam int BW   = 16;
  localparam int XW   = 32;
  localparam int TAPS = 3;
  localparam int IW   = 8;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  load_valid_in;
  logic                  load_ready_out;
  logic [BW-1:0]         b_in;
  logic [IW-1:0]         sweep_limit_in;
  logic                  x_valid_in;
  logic [XW-1:0]         x_in;
  logic [BW-1:0]         b_out;
  logic [2*TAPS*XW-1:0]  x_taps_out;
  logic [$clog2(N)-1:0]  row_out;
  logic                  start_out;
  logic                  sweep_done_out;
  logic [IW-1:0]         iter_out;
  logic                  done_out;
`ifdef GSBUF_CONVERGE_EN
  logic                  converged_out;
`endif

  int checks = 0;
  int errors = 0;

  gs_vector_buffer #(.N(N), .BW(BW), .XW(XW), .TAPS(TAPS), .IW(IW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_valid_in  (load_valid_in),
    .load_ready_out (load_ready_out),
    .b_in           (b_in),
    .sweep_limit_in (sweep_limit_in),
    .x_valid_in     (x_valid_in),
    .x_in           (x_in),
    .b_out          (b_out),
    .x_taps_out     (x_taps_out),
    .row_out        (row_out),
    .start_out      (start_out),
    .sweep_done_out (sweep_done_out),
    .iter_out       (iter_out),
    .done_out       (done_out)
`ifdef GSBUF_CONVERGE_EN
    ,
    .converged_out  (converged_out)
`endif
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic load_word(input int v, input int lim);
    load_valid_in  = 1'b1;
    b_in           = BW'(v);
    sweep_limit_in = IW'(lim);
    tick();
    load_valid_in  = 1'b0;
  endtask

  task automatic step_x(input int v);
    x_valid_in = 1'b1;
    x_in       = XW'(v);
    tick();
    x_valid_in = 1'b0;
  endtask

  function automatic logic [XW-1:0] tap(input int slot);
    return x_taps_out[slot*XW +: XW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_in = 1'b1; load_valid_in = 1'b0; b_in = '0; sweep_limit_in = '0;
    x_valid_in = 1'b0; x_in = '0;
    tick(); tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_ready", load_ready_out, 1);
    chk("rst_start", start_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_row", row_out, 0);
    chk("rst_iter", iter_out, 0);
    chk("rst_bout", b_out, 0);
    chk("rst_swdone", sweep_done_out, 0);
    for (int s = 0; s < 2*TAPS; s++) chk("rst_tap", tap(s), 0);

    // Load b = 1..16, limit 2 on the first word only, one gap in valid
    for (int i = 1; i <= N; i++) begin
      if (i == 5) tick();
      if (i == N) begin
        chk("load_ready_before_last", load_ready_out, 1);
        chk("load_start_before_last", start_out, 0);
      end
      load_word(i, (i == 1) ? 2 : 7);
    end
    chk("run_ready", load_ready_out, 0);
    chk("run_start", start_out, 1);
    chk("run_bout", b_out, 1);
    chk("run_row", row_out, 0);
    for (int s = 0; s < 2*TAPS; s++) chk("run_tap_zero", tap(s), 0);

    // Two sweeps with x = 100 + row
    for (int r = 0; r < 2*N; r++) begin
      if (r == 3) chk("s1_bout_row3", b_out, 4);
      if (r == 15) chk("swdone_low_15", sweep_done_out, 0);
      if (r == 16) begin
        chk("swdone_pulse", sweep_done_out, 1);
        chk("iter_after_s1", iter_out, 1);
        chk("s2_row0", row_out, 0);
        chk("s2_bout0", b_out, 1);
        chk("s2_upper1", tap(0), 101);
        chk("s2_upper2", tap(2), 102);
        chk("s2_upper3", tap(4), 103);
        chk("s2_lower1", tap(1), 0);
        chk("s2_lower2", tap(3), 0);
        chk("s2_lower3", tap(5), 0);
      end
      if (r == 17) chk("swdone_low_17", sweep_done_out, 0);
      if (r == 31) begin
        chk("s2_row15", row_out, 15);
        chk("s2_bout15", b_out, 16);
        chk("s2_r15_upper1", tap(0), 0);
        chk("s2_r15_upper3", tap(4), 0);
        chk("s2_r15_lower1", tap(1), 114);
        chk("s2_r15_lower2", tap(3), 113);
        chk("s2_r15_lower3", tap(5), 112);
      end
      step_x(100 + (r % N));
    end
    chk("done_flag", done_out, 1);
    chk("done_iter", iter_out, 2);
    chk("done_bout", b_out, 1);
    chk("done_row", row_out, 0);
    chk("done_start", start_out, 0);
    chk("done_ready", load_ready_out, 1);
    chk("done_swdone", sweep_done_out, 1);
    step_x(999);
    chk("done_hold_row", row_out, 0);
    chk("done_hold_iter", iter_out, 2);
    chk("done_hold_flag", done_out, 1);
    chk("done_hold_tap", tap(0), 101);
    chk("done_hold_swdone", sweep_done_out, 0);

    // Warm-start reload (limit 0 acts as 1), then x_valid 1,0,0,1
    for (int i = 0; i < N; i++) load_word(200 + i, 0);
    chk("warm_start", start_out, 1);
    chk("warm_bout", b_out, 200);
    chk("warm_upper1", tap(0), 101);
    chk("warm_upper2", tap(2), 102);
    step_x(500);
    chk("tog_row1", row_out, 1);
    chk("tog_bout1", b_out, 201);
    chk("tog_lower1", tap(1), 500);
    chk("tog_upper1", tap(0), 102);
    x_in = 777;
    tick(); tick();
    chk("idle_row", row_out, 1);
    chk("idle_lower1", tap(1), 500);
    chk("idle_upper1", tap(0), 102);
    chk("idle_bout", b_out, 201);
    step_x(501);
    chk("tog_row2", row_out, 2);
    chk("tog_lower1b", tap(1), 501);
    chk("tog_lower2b", tap(3), 500);
    chk("tog_lower3b", tap(5), 0);
    chk("tog_upper1b", tap(0), 103);
    chk("tog_bout2", b_out, 202);

    // Reset in the middle of RUN at row 7 with a simultaneous step
    for (int i = 0; i < 5; i++) step_x(600 + i);
    chk("pre_rst_row", row_out, 7);
    rst_in = 1'b1; x_valid_in = 1'b1; x_in = 5;
    tick();
    rst_in = 1'b0; x_valid_in = 1'b0;
    chk("mid_rst_ready", load_ready_out, 1);
    chk("mid_rst_start", start_out, 0);
    chk("mid_rst_row", row_out, 0);
    chk("mid_rst_iter", iter_out, 0);
    chk("mid_rst_bout", b_out, 0);
    chk("mid_rst_upper1", tap(0), 0);
    chk("mid_rst_upper2", tap(2), 0);
    chk("mid_rst_upper3", tap(4), 0);

    // Sweep limit 0 behaves as 1
    for (int i = 1; i <= N; i++) load_word(i, 0);
    for (int r = 0; r < N; r++) step_x(100 + r);
    chk("lim0_done", done_out, 1);
    chk("lim0_iter", iter_out, 1);
    chk("lim0_swdone", sweep_done_out, 1);
`ifdef GSBUF_CONVERGE_EN
    chk("lim0_not_conv", converged_out, 0);

    // Early stop: sweep 2 within 3 of sweep 1, limit 10
    for (int i = 1; i <= N; i++) load_word(i, 10);
    for (int r = 0; r < N; r++) step_x(300 + r);
    chk("conv_s1_start", start_out, 1);
    chk("conv_s1_iter", iter_out, 1);
    chk("conv_s1_flag", converged_out, 0);
    for (int r = 0; r < N; r++) step_x(303 + r);
    chk("conv_done", done_out, 1);
    chk("conv_iter", iter_out, 2);
    chk("conv_flag", converged_out, 1);
    load_word(7, 3);
    chk("conv_clear", converged_out, 0);
    chk("conv_reload_ready", load_ready_out, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
